ssm_mux_sched: RTL and testbench

- Substream-mux read scheduler for the VDC-M decoder front end.
- Owns the single rate-buffer read port and shares it between NUM_SSM substream parsers (bitparse instances, ssm_idx 0..NUM_SSM-1).
- Sequences a slice in three steps: prefills each parser's funnel shifter, then releases start_dec, then serves per-parser 128-bit mux-word requests round-robin until the slice's block count is reached.

---
 rtl/vdcm_ssm_pkg.sv | 21 ++
 rtl/ssm_mux_sched_if.sv | 28 ++
 rtl/ssm_rr_arb.sv | 37 +++
 rtl/ssm_mux_sched.sv | 170 +++++++++++++++++
 tb/tb_ssm_mux_sched.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/vdcm_ssm_pkg.sv
// Shared types and helpers for the substream-mux read scheduler.
//   sched_state_e : scheduler FSM states
//   NUM_SSM_DEF / MUX_W_DEF : default parser count and mux word width
//   idx_to_onehot : index -> one-hot conversion (callers truncate to their width)
package vdcm_ssm_pkg;

  localparam int unsigned NUM_SSM_DEF = 4;
  localparam int unsigned MUX_W_DEF   = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } sched_state_e;

  function automatic logic [31:0] idx_to_onehot(input int unsigned idx);
    return 32'(1) << idx;
  endfunction

endpackage

// File: rtl/ssm_mux_sched_if.sv
// Rate-buffer read port plus the shared parser delivery bus.
//   rb_data/rb_valid/rb_ready : rate-buffer head word handshake
//   ssm_req                   : per-parser word request pulses
//   ssm_data/ssm_wr           : delivered word and one-hot target strobe
//   master modport = scheduler side, slave modport = rate buffer + parsers
interface ssm_mux_sched_if #(
  parameter int unsigned NUM_SSM = vdcm_ssm_pkg::NUM_SSM_DEF,
  parameter int unsigned MUX_W   = vdcm_ssm_pkg::MUX_W_DEF
);

  logic [MUX_W-1:0]   rb_data;
  logic               rb_valid;
  logic               rb_ready;
  logic [NUM_SSM-1:0] ssm_req;
  logic [MUX_W-1:0]   ssm_data;
  logic [NUM_SSM-1:0] ssm_wr;

  modport master (
    input  rb_data, rb_valid, ssm_req,
    output rb_ready, ssm_data, ssm_wr
  );

  modport slave (
    output rb_data, rb_valid, ssm_req,
    input  rb_ready, ssm_data, ssm_wr
  );

endinterface

// File: rtl/ssm_rr_arb.sv
// Combinational round-robin arbiter: picks the lowest-index pending parser
// at or after rr_ptr, wrapping around.
//   pend       : pending request bits
//   rr_ptr     : search start index
//   gnt_onehot : one-hot grant, gnt_idx : granted index, any : some bit pending
module ssm_rr_arb
  import vdcm_ssm_pkg::*;
#(
  parameter  int unsigned NUM_SSM = NUM_SSM_DEF,
  localparam int unsigned IDX_W   = (NUM_SSM > 1) ? $clog2(NUM_SSM) : 1
) (
  input  logic [NUM_SSM-1:0] pend,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_SSM-1:0] gnt_onehot,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               any
);

  int unsigned idx;

  // Scan from rr_ptr upward; first pending bit wins.
  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    any        = 1'b0;
    idx        = 0;
    for (int unsigned off = 0; off < NUM_SSM; off++) begin
      idx = (32'(rr_ptr) + off) % NUM_SSM;
      if (!any && pend[IDX_W'(idx)]) begin
        any        = 1'b1;
        gnt_idx    = IDX_W'(idx);
        gnt_onehot = NUM_SSM'(idx_to_onehot(idx));
      end
    end
  end

endmodule

// File: rtl/ssm_mux_sched.sv
// Substream-mux read scheduler: owns the rate-buffer read port, prefills
// every parser with INIT_WORDS words, then serves parser requests
// round-robin until SLICE_BLKS blocks have been parsed.
//   clk, rstn     : clock, async active-low reset
//   slice_start   : begins a slice (IDLE only)
//   blk_tick      : one block fully parsed (RUN only)
//   start_dec     : parser enable, high in RUN
//   slice_done    : one-cycle end-of-slice pulse
//   busy          : not IDLE
//   err_underflow : sticky starvation flag
//   bus           : rate-buffer / parser bus (master side)
module ssm_mux_sched
  import vdcm_ssm_pkg::*;
#(
  parameter int unsigned NUM_SSM    = NUM_SSM_DEF,
  parameter int unsigned MUX_W      = MUX_W_DEF,
  parameter int unsigned INIT_WORDS = 2,
  parameter logic [15:0] SLICE_BLKS = 16'd1024,
  parameter logic [7:0]  STALL_MAX  = 8'd64
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            slice_start,
  input  logic            blk_tick,
  output logic            start_dec,
  output logic            slice_done,
  output logic            busy,
  output logic            err_underflow,
  ssm_mux_sched_if.master bus
);

  localparam int unsigned IDX_W      = (NUM_SSM > 1) ? $clog2(NUM_SSM) : 1;
  localparam int unsigned TOTAL_INIT = NUM_SSM * INIT_WORDS;
  localparam int unsigned WC_W       = $clog2(TOTAL_INIT + 1);
  localparam int unsigned SUB_W      = (INIT_WORDS > 1) ? $clog2(INIT_WORDS) : 1;

  sched_state_e       state_q, state_d;
  logic [NUM_SSM-1:0] pend_q, pend_d;
  logic [IDX_W-1:0]   rr_ptr_q, init_ssm_q, target;
  logic [WC_W-1:0]    word_cnt_q;
  logic [SUB_W-1:0]   sub_cnt_q;
  logic [15:0]        blk_cnt_q;
  logic [7:0]         stall_cnt_q;
  logic               rb_ready_q;
  logic [MUX_W-1:0]   ssm_data_q;
  logic [NUM_SSM-1:0] ssm_wr_q;
  logic [NUM_SSM-1:0] gnt_onehot;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_any;
  logic               hs, hs_init, hs_run, starving;

  assign bus.rb_ready = rb_ready_q;
  assign bus.ssm_data = ssm_data_q;
  assign bus.ssm_wr   = ssm_wr_q;

  ssm_rr_arb #(.NUM_SSM(NUM_SSM)) u_arb (
    .pend       (pend_q),
    .rr_ptr     (rr_ptr_q),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .any        (gnt_any)
  );

  assign hs       = bus.rb_valid & rb_ready_q;
  assign hs_init  = hs & (state_q == INIT);
  assign hs_run   = hs & (state_q == RUN) & gnt_any;
  assign starving = (state_q == RUN) && (pend_q != '0) && !bus.rb_valid;
  assign target   = (state_q == INIT) ? init_ssm_q : gnt_idx;

  // Next-state and pending-request update.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    unique case (state_q)
      IDLE: begin
        if (slice_start) begin
          state_d = INIT;
          pend_d  = '0;
        end
      end
      INIT: begin
        pend_d = '0;
        if (hs_init && word_cnt_q == WC_W'(TOTAL_INIT - 1)) state_d = RUN;
      end
      RUN: begin
        // A same-cycle re-request of the granted parser keeps its bit set.
        pend_d = (pend_q & ~(gnt_onehot & {NUM_SSM{hs_run}})) | bus.ssm_req;
        if (blk_tick && blk_cnt_q == SLICE_BLKS - 16'd1) begin
          state_d = DONE;
          pend_d  = '0;
        end
      end
      DONE: begin
        pend_d  = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= IDLE;
      pend_q        <= '0;
      rr_ptr_q      <= '0;
      init_ssm_q    <= '0;
      word_cnt_q    <= '0;
      sub_cnt_q     <= '0;
      blk_cnt_q     <= '0;
      stall_cnt_q   <= '0;
      rb_ready_q    <= 1'b0;
      ssm_data_q    <= '0;
      ssm_wr_q      <= '0;
      start_dec     <= 1'b0;
      slice_done    <= 1'b0;
      busy          <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      rb_ready_q <= (state_d == INIT) || ((state_d == RUN) && (pend_d != '0));
      start_dec  <= (state_d == RUN);
      slice_done <= (state_d == DONE);
      busy       <= (state_d != IDLE);

      if (hs_init || hs_run) begin
        ssm_data_q <= bus.rb_data;
        ssm_wr_q   <= NUM_SSM'(idx_to_onehot(32'(target)));
      end else begin
        ssm_wr_q   <= '0;
      end

      if (state_q == IDLE && slice_start) begin
        err_underflow <= 1'b0;
        rr_ptr_q      <= '0;
        init_ssm_q    <= '0;
        word_cnt_q    <= '0;
        sub_cnt_q     <= '0;
        blk_cnt_q     <= '0;
      end

      // Prefill: INIT_WORDS consecutive words per parser.
      if (hs_init) begin
        word_cnt_q <= word_cnt_q + WC_W'(1);
        if (sub_cnt_q == SUB_W'(INIT_WORDS - 1)) begin
          sub_cnt_q  <= '0;
          init_ssm_q <= init_ssm_q + IDX_W'(1);
        end else begin
          sub_cnt_q  <= sub_cnt_q + SUB_W'(1);
        end
      end

      if (hs_run) begin
        rr_ptr_q <= (gnt_idx == IDX_W'(NUM_SSM - 1)) ? '0 : gnt_idx + IDX_W'(1);
      end

      if (state_q == RUN && blk_tick) blk_cnt_q <= blk_cnt_q + 16'd1;

      // Saturating starvation counter; flag sets on the cycle it reaches STALL_MAX.
      if (starving) begin
        if (stall_cnt_q != 8'hFF) stall_cnt_q <= stall_cnt_q + 8'd1;
        if (stall_cnt_q >= STALL_MAX - 8'd1) err_underflow <= 1'b1;
      end else begin
        stall_cnt_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ssm_mux_sched.sv
// Directed bench for ssm_mux_sched (NUM_SSM=4, INIT_WORDS=2, SLICE_BLKS=3,
// STALL_MAX=8): prefill order, round-robin, re-request, starvation, slice
// end and mid-slice reset.
module tb_ssm_mux_sched;

  localparam int unsigned N = 4;
  localparam int unsigned W = 128;

  logic clk = 1'b0;
  logic rstn;
  logic slice_start, blk_tick;
  logic start_dec, slice_done, busy, err_underflow;
  int   checks = 0;
  int   errors = 0;

  ssm_mux_sched_if #(.NUM_SSM(N), .MUX_W(W)) bus ();

  ssm_mux_sched #(
    .NUM_SSM(N), .MUX_W(W), .INIT_WORDS(2),
    .SLICE_BLKS(16'd3), .STALL_MAX(8'd8)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .slice_start   (slice_start),
    .blk_tick      (blk_tick),
    .start_dec     (start_dec),
    .slice_done    (slice_done),
    .busy          (busy),
    .err_underflow (err_underflow),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] word(input int k);
    return {4{32'hC0DE_0000 | 32'(k)}};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; slice_start = 1'b0; blk_tick = 1'b0;
    bus.rb_valid = 1'b0; bus.rb_data = '0; bus.ssm_req = '0;
    step(); step();
    checks++; if (bus.rb_ready !== 1'b0) begin errors++; $display("FAIL reset_rb_ready got %b want 0", bus.rb_ready); end
    checks++; if (bus.ssm_wr !== 4'b0) begin errors++; $display("FAIL reset_ssm_wr got %b want 0000", bus.ssm_wr); end
    checks++; if (bus.ssm_data !== '0) begin errors++; $display("FAIL reset_ssm_data got %h want 0", bus.ssm_data); end
    checks++; if ({start_dec, slice_done, busy, err_underflow} !== 4'b0) begin errors++; $display("FAIL reset_ctrl got %b want 0000", {start_dec, slice_done, busy, err_underflow}); end
    rstn = 1'b1;
    step();
  endtask

  task automatic test_prefill(input int base);
    logic [N-1:0] exp_wr;
    slice_start = 1'b1; bus.rb_valid = 1'b1; bus.rb_data = word(base);
    step();
    slice_start = 1'b0;
    checks++; if ({bus.rb_ready, busy, start_dec} !== 3'b110) begin errors++; $display("FAIL prefill_enter ready/busy/start got %b want 110", {bus.rb_ready, busy, start_dec}); end
    for (int k = 0; k < 8; k++) begin
      step();
      exp_wr = 4'b0001 << (k / 2);
      checks++; if (bus.ssm_wr !== exp_wr) begin errors++; $display("FAIL prefill_wr k=%0d got %b want %b", k, bus.ssm_wr, exp_wr); end
      checks++; if (bus.ssm_data !== word(base + k)) begin errors++; $display("FAIL prefill_data k=%0d got %h want %h", k, bus.ssm_data, word(base + k)); end
      checks++; if (start_dec !== (k == 7)) begin errors++; $display("FAIL prefill_start_dec k=%0d got %b want %b", k, start_dec, (k == 7)); end
      bus.rb_data = word(base + k + 1);
    end
    checks++; if (bus.rb_ready !== 1'b0) begin errors++; $display("FAIL prefill_ready_after got %b want 0", bus.rb_ready); end
    bus.rb_valid = 1'b0;
    step();
    checks++; if (bus.ssm_wr !== 4'b0) begin errors++; $display("FAIL prefill_no_extra got %b want 0000", bus.ssm_wr); end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_wr;
    bus.rb_valid = 1'b1; bus.rb_data = word(10); bus.ssm_req = 4'b1111;
    step();
    bus.ssm_req = '0;
    checks++; if (bus.rb_ready !== 1'b1) begin errors++; $display("FAIL rr_ready_rise got %b want 1", bus.rb_ready); end
    for (int i = 0; i < 4; i++) begin
      step();
      exp_wr = 4'b0001 << i;
      checks++; if (bus.ssm_wr !== exp_wr) begin errors++; $display("FAIL rr_wr i=%0d got %b want %b", i, bus.ssm_wr, exp_wr); end
      checks++; if (bus.ssm_data !== word(10 + i)) begin errors++; $display("FAIL rr_data i=%0d got %h want %h", i, bus.ssm_data, word(10 + i)); end
      checks++; if (bus.rb_ready !== (i != 3)) begin errors++; $display("FAIL rr_ready i=%0d got %b want %b", i, bus.rb_ready, (i != 3)); end
      bus.rb_data = word(11 + i);
    end
    step();
    checks++; if (bus.ssm_wr !== 4'b0) begin errors++; $display("FAIL rr_idle_wr got %b want 0000", bus.ssm_wr); end
    bus.rb_valid = 1'b0;
  endtask

  task automatic test_rereq();
    bus.ssm_req = 4'b0010;
    step();
    bus.ssm_req = 4'b0011; bus.rb_valid = 1'b1; bus.rb_data = word(20);
    step();
    bus.ssm_req = '0; bus.rb_data = word(21);
    checks++; if (bus.ssm_wr !== 4'b0010) begin errors++; $display("FAIL rereq_first got %b want 0010", bus.ssm_wr); end
    step();
    bus.rb_data = word(22);
    checks++; if (bus.ssm_wr !== 4'b0001) begin errors++; $display("FAIL rereq_ssm0 got %b want 0001", bus.ssm_wr); end
    step();
    checks++; if (bus.ssm_wr !== 4'b0010) begin errors++; $display("FAIL rereq_second got %b want 0010", bus.ssm_wr); end
    checks++; if (bus.ssm_data !== word(22)) begin errors++; $display("FAIL rereq_data got %h want %h", bus.ssm_data, word(22)); end
    checks++; if (bus.rb_ready !== 1'b0) begin errors++; $display("FAIL rereq_ready got %b want 0", bus.rb_ready); end
    bus.rb_valid = 1'b0;
  endtask

  task automatic test_starvation();
    bus.ssm_req = 4'b0100;
    step();
    bus.ssm_req = '0;
    for (int i = 0; i < 7; i++) step();
    checks++; if (err_underflow !== 1'b0) begin errors++; $display("FAIL starve_early got %b want 0", err_underflow); end
    step();
    checks++; if (err_underflow !== 1'b1) begin errors++; $display("FAIL starve_set got %b want 1", err_underflow); end
    bus.rb_valid = 1'b1; bus.rb_data = word(30);
    step();
    bus.rb_valid = 1'b0;
    checks++; if (bus.ssm_wr !== 4'b0100) begin errors++; $display("FAIL starve_deliver_wr got %b want 0100", bus.ssm_wr); end
    checks++; if (bus.ssm_data !== word(30)) begin errors++; $display("FAIL starve_deliver_data got %h want %h", bus.ssm_data, word(30)); end
    step();
    checks++; if ({err_underflow, bus.ssm_wr} !== 5'b10000) begin errors++; $display("FAIL starve_sticky err/wr got %b want 10000", {err_underflow, bus.ssm_wr}); end
  endtask

  task automatic test_slice_end();
    slice_start = 1'b1;
    step();
    slice_start = 1'b0;
    checks++; if ({busy, start_dec, err_underflow} !== 3'b111) begin errors++; $display("FAIL start_in_run busy/start/err got %b want 111", {busy, start_dec, err_underflow}); end
    for (int t = 0; t < 2; t++) begin
      blk_tick = 1'b1; step();
      blk_tick = 1'b0; step();
      checks++; if (slice_done !== 1'b0) begin errors++; $display("FAIL early_done t=%0d got %b want 0", t, slice_done); end
    end
    blk_tick = 1'b1;
    step();
    blk_tick = 1'b0;
    checks++; if ({slice_done, start_dec, busy, bus.rb_ready} !== 4'b1010) begin errors++; $display("FAIL done_cycle done/start/busy/ready got %b want 1010", {slice_done, start_dec, busy, bus.rb_ready}); end
    step();
    checks++; if ({slice_done, busy} !== 2'b00) begin errors++; $display("FAIL after_done done/busy got %b want 00", {slice_done, busy}); end
  endtask

  task automatic test_reset_mid_run();
    test_prefill(40);
    checks++; if (err_underflow !== 1'b0) begin errors++; $display("FAIL err_cleared got %b want 0", err_underflow); end
    bus.ssm_req = 4'b1010;
    step();
    bus.ssm_req = '0;
    checks++; if (bus.rb_ready !== 1'b1) begin errors++; $display("FAIL midrst_pend_ready got %b want 1", bus.rb_ready); end
    bus.rb_valid = 1'b1; bus.rb_data = word(50);
    #2 rstn = 1'b0;
    #1;
    checks++; if ({bus.rb_ready, start_dec, busy, slice_done, err_underflow} !== 5'b0) begin errors++; $display("FAIL midrst_ctrl got %b want 00000", {bus.rb_ready, start_dec, busy, slice_done, err_underflow}); end
    checks++; if (bus.ssm_data !== '0) begin errors++; $display("FAIL midrst_data got %h want 0", bus.ssm_data); end
    step(); step();
    rstn = 1'b1;
    bus.ssm_req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if ({bus.ssm_wr, bus.rb_ready, busy} !== 6'b0) begin errors++; $display("FAIL post_rst i=%0d wr/ready/busy got %b want 000000", i, {bus.ssm_wr, bus.rb_ready, busy}); end
    end
    bus.ssm_req = '0; bus.rb_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_prefill(0);
    test_round_robin();
    test_rereq();
    test_starvation();
    test_slice_end();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
